// File: rtl/addsub_pkg.sv
// Shared definitions for the registered adder/subtractor: width helpers,
// the legal latency range and the operation encoding.
package addsub_pkg;

  localparam int MIN_LATENCY = 1;
  localparam int MAX_LATENCY = 4;

  // Operation selected by sub_i.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One guard bit above the widest operand makes add and signed subtract
  // exact; for unsigned subtract the extra MSB doubles as the borrow flag.
  function automatic int out_w(input int w1, input int w2);
    return max_w(w1, w2) + 1;
  endfunction

endpackage

// File: rtl/reg_addsub_if.sv
// Operand/result bundle for reg_addsub. The master side drives the operands
// and qualifiers; the slave side (the arithmetic block) returns the result.
interface reg_addsub_if #(
  parameter int DATA_WIDTH_1 = 16,
  parameter int DATA_WIDTH_2 = 16
) ();

  localparam int OUT_W = addsub_pkg::out_w(DATA_WIDTH_1, DATA_WIDTH_2);

  logic                    valid_i;
  logic                    sub_i;
  logic [DATA_WIDTH_1-1:0] data1_i;
  logic [DATA_WIDTH_2-1:0] data2_i;
  logic [OUT_W-1:0]        data_o;
  logic                    valid_o;

  modport master (
    output valid_i,
    output sub_i,
    output data1_i,
    output data2_i,
    input  data_o,
    input  valid_o
  );

  modport slave (
    input  valid_i,
    input  sub_i,
    input  data1_i,
    input  data2_i,
    output data_o,
    output valid_o
  );

endinterface

// File: rtl/addsub_pipe_reg.sv
// One pipeline stage: a plain WIDTH-bit register with synchronous
// active-low clear. It loads every cycle; there is no enable or stall.
module addsub_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  assign data_d = d_i;

  // Clear the stage on reset, otherwise capture the incoming word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_addsub.sv
// Registered two-operand adder/subtractor. Operands are extended to
// OUT_W = max(W1, W2) + 1 bits, added or subtracted, and the {valid, result}
// word is carried through LATENCY identical clearable register stages.
module reg_addsub
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH_1 = 16,
  parameter int DATA_WIDTH_2 = 16,
  parameter int SIGNED       = 0,
  parameter int LATENCY      = 1
) (
  input logic         clk,
  input logic         rst_n,
  reg_addsub_if.slave bus
);

  localparam int OUT_W   = out_w(DATA_WIDTH_1, DATA_WIDTH_2);
  localparam int STAGE_W = OUT_W + 1;

  if ((LATENCY < MIN_LATENCY) || (LATENCY > MAX_LATENCY)) begin : g_bad_latency
    $error("reg_addsub: LATENCY=%0d is outside %0d..%0d",
           LATENCY, MIN_LATENCY, MAX_LATENCY);
  end

  // Extend operand 1 to the result width; the fill bit is the operand MSB
  // only for two's-complement operands.
  function automatic logic signed [OUT_W-1:0] extend1(input logic [DATA_WIDTH_1-1:0] v);
    logic fill;
    fill = (SIGNED != 0) ? v[DATA_WIDTH_1-1] : 1'b0;
    return {{(OUT_W - DATA_WIDTH_1){fill}}, v};
  endfunction

  // Same extension for operand 2, which may have a different width.
  function automatic logic signed [OUT_W-1:0] extend2(input logic [DATA_WIDTH_2-1:0] v);
    logic fill;
    fill = (SIGNED != 0) ? v[DATA_WIDTH_2-1] : 1'b0;
    return {{(OUT_W - DATA_WIDTH_2){fill}}, v};
  endfunction

  op_e                     op;
  logic signed [OUT_W-1:0] op1_ext;
  logic signed [OUT_W-1:0] op2_ext;
  logic signed [OUT_W-1:0] result;

  // Extend both operands and form the result modulo 2^OUT_W.
  always_comb begin
    op      = op_e'(bus.sub_i);
    op1_ext = extend1(bus.data1_i);
    op2_ext = extend2(bus.data2_i);
    if (op == OP_SUB) begin
      result = op1_ext - op2_ext;
    end else begin
      result = op1_ext + op2_ext;
    end
  end

  logic [STAGE_W-1:0] stage_d [LATENCY];
  logic [STAGE_W-1:0] stage_q [LATENCY];

  // ---- stage 1 boundary: arithmetic result and valid enter the pipe ----
  assign stage_d[0] = {bus.valid_i, result};

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    if (s > 0) begin : g_chain
      // ---- stage boundary: previous stage feeds the next ----
      assign stage_d[s] = stage_q[s-1];
    end

    addsub_pipe_reg #(
      .WIDTH (STAGE_W)
    ) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (stage_d[s]),
      .q_o   (stage_q[s])
    );
  end

  // ---- output boundary: last stage drives the ports directly ----
  assign bus.valid_o = stage_q[LATENCY-1][STAGE_W-1];
  assign bus.data_o  = stage_q[LATENCY-1][OUT_W-1:0];

endmodule

// File: tb/tb_reg_addsub.sv
// Scoreboard bench for reg_addsub: five instances cover the default
// configuration, signed operands, mixed widths (unsigned and signed) and a
// three-stage pipeline used for latency, streaming and reset behaviour.
module tb_reg_addsub;

  logic clk;
  logic rst_n;
  int   pcnt = 0;
  int   n_checks = 0;
  int   n_err = 0;

  typedef struct {
    int          id;
    logic [16:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges; stable whenever the falling edge is used.
  always @(posedge clk) pcnt <= pcnt + 1;

  reg_addsub_if #(.DATA_WIDTH_1(16), .DATA_WIDTH_2(16)) if0 ();
  reg_addsub_if #(.DATA_WIDTH_1(16), .DATA_WIDTH_2(16)) if1 ();
  reg_addsub_if #(.DATA_WIDTH_1(8),  .DATA_WIDTH_2(16)) if2 ();
  reg_addsub_if #(.DATA_WIDTH_1(8),  .DATA_WIDTH_2(16)) if3 ();
  reg_addsub_if #(.DATA_WIDTH_1(16), .DATA_WIDTH_2(16)) if4 ();

  reg_addsub #(.DATA_WIDTH_1(16), .DATA_WIDTH_2(16), .SIGNED(0), .LATENCY(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  reg_addsub #(.DATA_WIDTH_1(16), .DATA_WIDTH_2(16), .SIGNED(1), .LATENCY(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  reg_addsub #(.DATA_WIDTH_1(8),  .DATA_WIDTH_2(16), .SIGNED(0), .LATENCY(1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  reg_addsub #(.DATA_WIDTH_1(8),  .DATA_WIDTH_2(16), .SIGNED(1), .LATENCY(1))
    u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  reg_addsub #(.DATA_WIDTH_1(16), .DATA_WIDTH_2(16), .SIGNED(0), .LATENCY(3))
    u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  logic        vo   [5];
  logic [16:0] dout [5];

  assign vo[0] = if0.valid_o;  assign dout[0] = if0.data_o;
  assign vo[1] = if1.valid_o;  assign dout[1] = if1.data_o;
  assign vo[2] = if2.valid_o;  assign dout[2] = if2.data_o;
  assign vo[3] = if3.valid_o;  assign dout[3] = if3.data_o;
  assign vo[4] = if4.valid_o;  assign dout[4] = if4.data_o;

  // Monitor: on every falling edge, match each presented result against the
  // oldest outstanding expectation for that instance, then flag overdue ones.
  int mon_idx;
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (vo[k] === 1'b1) begin
        mon_idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (mon_idx < 0 && sb[i].id == k) mon_idx = i;
        end
        n_checks++;
        if (mon_idx < 0) begin
          n_err++;
          $display("FAIL unexpected_valid dut%0d: got valid_o=1 data_o=%05h, required valid_o=0",
                   k, dout[k]);
        end else begin
          if (dout[k] !== sb[mon_idx].data) begin
            n_err++;
            $display("FAIL %s data dut%0d: got %05h, required %05h",
                     sb[mon_idx].name, k, dout[k], sb[mon_idx].data);
          end
          n_checks++;
          if (sb[mon_idx].due != pcnt) begin
            n_err++;
            $display("FAIL %s timing dut%0d: arrived at edge %0d, required edge %0d",
                     sb[mon_idx].name, k, pcnt, sb[mon_idx].due);
          end
          sb.delete(mon_idx);
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < pcnt) begin
        n_checks++;
        n_err++;
        $display("FAIL %s missing dut%0d: no valid_o by edge %0d, required at edge %0d",
                 sb[i].name, sb[i].id, pcnt, sb[i].due);
        sb.delete(i);
      end
    end
  end

  task automatic chk(input string nm, input logic [16:0] got, input logic [16:0] req);
    n_checks++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %05h, required %05h", nm, got, req);
    end
  endtask

  task automatic clear_valids();
    if0.valid_i = 1'b0;
    if1.valid_i = 1'b0;
    if2.valid_i = 1'b0;
    if3.valid_i = 1'b0;
    if4.valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      clear_valids();
    end
  endtask

  // Present one qualified sample to instance id for exactly one edge and
  // record the hand-computed result with the edge it must appear after.
  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic [16:0] e, input string nm);
    exp_t t;
    @(negedge clk);
    #1;
    clear_valids();
    case (id)
      0: begin if0.data1_i = a;      if0.data2_i = b; if0.sub_i = sub; if0.valid_i = 1'b1; end
      1: begin if1.data1_i = a;      if1.data2_i = b; if1.sub_i = sub; if1.valid_i = 1'b1; end
      2: begin if2.data1_i = a[7:0]; if2.data2_i = b; if2.sub_i = sub; if2.valid_i = 1'b1; end
      3: begin if3.data1_i = a[7:0]; if3.data2_i = b; if3.sub_i = sub; if3.valid_i = 1'b1; end
      default: begin if4.data1_i = a; if4.data2_i = b; if4.sub_i = sub; if4.valid_i = 1'b1; end
    endcase
    t.id   = id;
    t.data = e;
    t.due  = pcnt + ((id == 4) ? 3 : 1);
    t.name = nm;
    sb.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held from time zero while instances see live, qualified inputs.
    rst_n = 1'b0;
    clear_valids();
    if0.sub_i = 1'b0; if0.data1_i = 16'h1234; if0.data2_i = 16'h4321; if0.valid_i = 1'b1;
    if1.sub_i = 1'b0; if1.data1_i = '0; if1.data2_i = '0;
    if2.sub_i = 1'b0; if2.data1_i = '0; if2.data2_i = '0;
    if3.sub_i = 1'b0; if3.data1_i = '0; if3.data2_i = '0;
    if4.sub_i = 1'b0; if4.data1_i = 16'h5555; if4.data2_i = 16'h1111; if4.valid_i = 1'b1;

    @(negedge clk);
    chk("powerup_data_dut0",  if0.data_o, 17'h0);
    chk("powerup_valid_dut0", {16'h0, if0.valid_o}, 17'h0);
    chk("powerup_data_dut4",  if4.data_o, 17'h0);
    chk("powerup_valid_dut4", {16'h0, if4.valid_o}, 17'h0);
    #1;
    clear_valids();
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Defaults: unsigned 16/16, one stage.
    issue(0, 16'h52F2, 16'h3671, 1'b0, 17'h08963, "add_basic1");
    issue(0, 16'h52F2, 16'h2234, 1'b0, 17'h07526, "add_basic2");
    issue(0, 16'h8929, 16'h2234, 1'b0, 17'h0AB5D, "add_basic3");
    issue(0, 16'h8712, 16'h4142, 1'b0, 17'h0C854, "add_basic4");
    issue(0, 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, "add_carry");
    issue(0, 16'h0000, 16'h0001, 1'b1, 17'h1FFFF, "sub_borrow");
    issue(0, 16'h8000, 16'h0001, 1'b1, 17'h07FFF, "sub_nowrap");
    idle(2);

    // Signed 16/16.
    issue(1, 16'h8000, 16'h8000, 1'b0, 17'h10000, "sadd_minmin");
    issue(1, 16'h7FFF, 16'h8000, 1'b1, 17'h0FFFF, "ssub_maxmin");
    issue(1, 16'hFFFF, 16'h0001, 1'b0, 17'h00000, "sadd_m1p1");
    issue(1, 16'h0005, 16'h0007, 1'b1, 17'h1FFFE, "ssub_neg");
    idle(2);

    // Mixed widths 8/16.
    issue(2, 16'h00FF, 16'hFFFF, 1'b0, 17'h100FE, "mix_uadd");
    issue(2, 16'h00FF, 16'h0001, 1'b1, 17'h000FE, "mix_usub");
    issue(3, 16'h00FF, 16'h0001, 1'b0, 17'h00000, "mix_sadd");
    issue(3, 16'h0080, 16'h0001, 1'b1, 17'h1FF7F, "mix_ssub");
    idle(2);

    // Three-stage pipe: isolated pulse, then a back-to-back burst.
    issue(4, 16'h0001, 16'h0002, 1'b0, 17'h00003, "lat3_pulse");
    idle(5);
    issue(4, 16'h1234, 16'h1111, 1'b0, 17'h02345, "lat3_burst1");
    issue(4, 16'h0010, 16'h0001, 1'b1, 17'h0000F, "lat3_burst2");
    issue(4, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, "lat3_burst3");
    idle(5);

    // Reset for one edge while two results are in flight.
    issue(4, 16'h00AA, 16'h0011, 1'b0, 17'h000BB, "flight1");
    issue(4, 16'h00BB, 16'h0011, 1'b0, 17'h000CC, "flight2");
    @(negedge clk);
    #1;
    clear_valids();
    if4.data1_i = '0;
    if4.data2_i = '0;
    if4.sub_i   = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midreset_data_dut4",  if4.data_o, 17'h0);
    chk("midreset_valid_dut4", {16'h0, if4.valid_o}, 17'h0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postreset_valid_dut4", {16'h0, if4.valid_o}, 17'h0);
      chk("postreset_data_dut4",  if4.data_o, 17'h0);
    end

    // Behaves like power-up after release.
    issue(4, 16'h0001, 16'h0002, 1'b0, 17'h00003, "postreset_first");
    idle(6);

    chk("scoreboard_drained", 17'(sb.size()), 17'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
